// File: rtl/dispensador_troco_if.sv
// Command, coin-ejector and status signals between the vending FSM and the change dispenser.
interface dispensador_troco_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_candy;
    logic [3:0] cmd_change;
    logic       candy_out;
    logic [1:0] coin_out;
    logic       coin_valid;
    logic       coin_ack;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output cmd_valid, cmd_candy, cmd_change, coin_ack,
        input  cmd_ready, candy_out, coin_out, coin_valid, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_candy, cmd_change, coin_ack,
        output cmd_ready, candy_out, coin_out, coin_valid, busy, done, err
    );
endinterface

// File: rtl/dispensador_troco.sv
// Candy release and greedy change payout (25c/10c/5c) with coin-ejector handshake.
// Optional feature: define DISP_TIMEOUT_EN to trap a stuck ejector in ERR after 256 WAIT_ACK cycles.
//
// state    | meaning
// IDLE     | ready for a command
// CANDY    | one-cycle candy release strobe
// PAY      | pick next coin from remaining change
// WAIT_ACK | coin request held until the ejector acknowledges
// DONE     | one-cycle completion strobe
// ERR      | ejector timed out, held until reset
module dispensador_troco (
    input  logic                 clk,
    input  logic                 r,
    dispensador_troco_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE, CANDY, PAY, WAIT_ACK, DONE, ERR
    } state_t;

    state_t     state;
    logic [3:0] rem;
`ifdef DISP_TIMEOUT_EN
    logic [7:0] cnt;
`endif

    function automatic logic [1:0] coin_pick(input logic [3:0] amount);
        if (amount >= 4'd5)      coin_pick = 2'b11;
        else if (amount >= 4'd2) coin_pick = 2'b10;
        else                     coin_pick = 2'b01;
    endfunction

    function automatic logic [3:0] coin_units(input logic [1:0] coin);
        case (coin)
            2'b11:   coin_units = 4'd5;
            2'b10:   coin_units = 4'd2;
            default: coin_units = 4'd1;
        endcase
    endfunction

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state          <= IDLE;
            rem            <= 4'd0;
            bus.coin_out   <= 2'b00;
            bus.coin_valid <= 1'b0;
            bus.candy_out  <= 1'b0;
            bus.done       <= 1'b0;
            bus.busy       <= 1'b0;
            bus.err        <= 1'b0;
            bus.cmd_ready  <= 1'b1;
`ifdef DISP_TIMEOUT_EN
            cnt            <= 8'd0;
`endif
        end else begin
            bus.candy_out <= 1'b0;
            bus.done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        rem           <= bus.cmd_change;
                        bus.cmd_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        if (bus.cmd_candy) begin
                            state         <= CANDY;
                            bus.candy_out <= 1'b1;
                        end else if (bus.cmd_change != 4'd0) begin
                            state <= PAY;
                        end else begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end
                    end
                end
                CANDY: begin
                    if (rem != 4'd0) begin
                        state <= PAY;
                    end else begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end
                end
                PAY: begin
                    bus.coin_out   <= coin_pick(rem);
                    bus.coin_valid <= 1'b1;
                    state          <= WAIT_ACK;
`ifdef DISP_TIMEOUT_EN
                    cnt            <= 8'd0;
`endif
                end
                WAIT_ACK: begin
                    // ack wins over a simultaneous timeout
                    if (bus.coin_ack) begin
                        rem            <= rem - coin_units(bus.coin_out);
                        bus.coin_out   <= 2'b00;
                        bus.coin_valid <= 1'b0;
                        if (rem == coin_units(bus.coin_out)) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state <= PAY;
                        end
                    end
`ifdef DISP_TIMEOUT_EN
                    else if (cnt == 8'd255) begin
                        state          <= ERR;
                        bus.err        <= 1'b1;
                        bus.coin_out   <= 2'b00;
                        bus.coin_valid <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
`endif
                end
                DONE: begin
                    state         <= IDLE;
                    bus.busy      <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state          <= IDLE;
                    bus.coin_out   <= 2'b00;
                    bus.coin_valid <= 1'b0;
                    bus.busy       <= 1'b0;
                    bus.cmd_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
